// File: rtl/mac_seq_ctrl.sv
// Sequencer for the minifloat MAC pipeline: accepts one dot-product job, streams operands,
// drives stage/accumulator enables and hands the result off over valid/ready.
module mac_seq_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      cfg_len,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  acc_en,
  output logic                  acc_clr,
  output logic [LEN_W-1:0]      term_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  state_t                state;
  logic [LEN_W-1:0]      len_q;
  logic [NUM_STAGES-1:0] v;
  logic [NUM_STAGES-1:0] f;
  logic                  accept;
  logic                  last;

  assign busy     = (state != IDLE);
  assign in_ready = (state == RUN);
  assign accept   = in_valid & in_ready;
  assign last     = (term_idx == len_q - LEN_W'(1));

  // Pipeline enables follow the valid token as it walks through the stages.
  assign stage_en = {v[NUM_STAGES-2:0], accept};
  assign acc_en   = v[NUM_STAGES-1];
  assign acc_clr  = f[NUM_STAGES-1];
  assign done     = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      term_idx  <= '0;
      v         <= '0;
      f         <= '0;
      out_valid <= 1'b0;
    end else begin
      v <= {v[NUM_STAGES-2:0], accept};
      f <= {f[NUM_STAGES-2:0], accept & (term_idx == '0)};
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
            term_idx <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (last) state <= DRAIN;
            else      term_idx <= term_idx + LEN_W'(1);
          end
        end
        DRAIN: begin
          // Only the last token is left and it sits at the accumulator this cycle.
          if (v[NUM_STAGES-2:0] == '0) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
